// File: rtl/relu_mac_datapath.sv
// Two-lane signed MAC with ReLU/requantize feeding a result shift register.
// Build option MAC_ACC_SAT_EN: saturating accumulate with sticky acc_ovf (otherwise wrap, acc_ovf=0).
module relu_mac_datapath #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int FRAC_BITS  = 4,
   parameter int OUT_DEPTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            reset,
   input  logic [DATA_WIDTH-1:0]           mem_data_a,
   input  logic [2*DATA_WIDTH-1:0]         mem_data_w,
   input  logic [1:0]                      mac_en,
   input  logic [1:0]                      mac_clr,
   input  logic [1:0]                      r_sh_en,
   output logic [OUT_DEPTH*DATA_WIDTH-1:0] result_vec,
   output logic [$clog2(OUT_DEPTH+1)-1:0]  result_cnt,
   output logic                            acc_ovf,
   output logic                            res_drop
);

   localparam int CNT_W = $clog2(OUT_DEPTH+1);
   localparam int DW    = DATA_WIDTH;
   localparam int AW    = ACC_WIDTH;
   localparam logic signed [AW-1:0] Q_MAX   = AW'((1 << (DW-1)) - 1);
   localparam logic [CNT_W:0]       DEPTH_C = (CNT_W+1)'(OUT_DEPTH);

   logic [1:0] mac_en_d, mac_clr_d, r_sh_en_d;
   logic signed [AW-1:0] acc [2];
   logic signed [AW-1:0] acc_nxt [2];
   logic signed [AW-1:0] prod_ext [2];
   logic signed [AW-1:0] add_res [2];
   logic signed [AW-1:0] shifted [2];
   logic signed [2*DW-1:0] prod [2];
   logic [DW-1:0] q [2];
   logic [1:0] lane_ovf;
   logic [OUT_DEPTH*DW-1:0] vec_nxt;
   logic [CNT_W:0] pushes, cnt_sum;
`ifdef MAC_ACC_SAT_EN
   logic signed [AW:0] sum_ext [2];
`endif

   always_comb begin
      lane_ovf = 2'b00;
      for (int i = 0; i < 2; i++) begin
         prod[i]     = $signed(mem_data_a) * $signed(mem_data_w[i*DW +: DW]);
         prod_ext[i] = {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
`ifdef MAC_ACC_SAT_EN
         sum_ext[i] = {acc[i][AW-1], acc[i]} + {prod_ext[i][AW-1], prod_ext[i]};
         if (sum_ext[i][AW] != sum_ext[i][AW-1]) begin
            lane_ovf[i] = mac_en_d[i] & ~mac_clr_d[i];
            add_res[i]  = sum_ext[i][AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
         end else begin
            add_res[i] = sum_ext[i][AW-1:0];
         end
`else
         add_res[i] = acc[i] + prod_ext[i];
`endif
         case ({mac_clr_d[i], mac_en_d[i]})
            2'b10:   acc_nxt[i] = '0;
            2'b11:   acc_nxt[i] = prod_ext[i];
            2'b01:   acc_nxt[i] = add_res[i];
            default: acc_nxt[i] = acc[i];
         endcase
         // ReLU then requantize; pushes see the accumulator before this edge's update
         shifted[i] = acc[i] >>> FRAC_BITS;
         if (acc[i] <= 0)
            q[i] = '0;
         else if (shifted[i] > Q_MAX)
            q[i] = Q_MAX[DW-1:0];
         else
            q[i] = shifted[i][DW-1:0];
      end

      case (r_sh_en_d)
         2'b01:   vec_nxt = {result_vec[(OUT_DEPTH-1)*DW-1:0], q[0]};
         2'b10:   vec_nxt = {result_vec[(OUT_DEPTH-1)*DW-1:0], q[1]};
         2'b11:   vec_nxt = {result_vec[(OUT_DEPTH-2)*DW-1:0], q[0], q[1]};
         default: vec_nxt = result_vec;
      endcase
      pushes  = (CNT_W+1)'(r_sh_en_d[0]) + (CNT_W+1)'(r_sh_en_d[1]);
      cnt_sum = {1'b0, result_cnt} + pushes;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mac_en_d   <= '0;
         mac_clr_d  <= '0;
         r_sh_en_d  <= '0;
         acc[0]     <= '0;
         acc[1]     <= '0;
         result_vec <= '0;
         result_cnt <= '0;
         res_drop   <= 1'b0;
      end else if (reset) begin
         mac_en_d   <= '0;
         mac_clr_d  <= '0;
         r_sh_en_d  <= '0;
         acc[0]     <= '0;
         acc[1]     <= '0;
         result_vec <= '0;
         result_cnt <= '0;
         res_drop   <= 1'b0;
      end else begin
         mac_en_d   <= mac_en;
         mac_clr_d  <= mac_clr;
         r_sh_en_d  <= r_sh_en;
         acc[0]     <= acc_nxt[0];
         acc[1]     <= acc_nxt[1];
         result_vec <= vec_nxt;
         if (cnt_sum > DEPTH_C) begin
            result_cnt <= DEPTH_C[CNT_W-1:0];
            res_drop   <= 1'b1;
         end else begin
            result_cnt <= cnt_sum[CNT_W-1:0];
         end
      end
   end

`ifdef MAC_ACC_SAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_ovf <= 1'b0;
      else if (reset)
         acc_ovf <= 1'b0;
      else if (|lane_ovf)
         acc_ovf <= 1'b1;
   end
`else
   assign acc_ovf = 1'b0;
   logic unused_ovf;
   assign unused_ovf = |lane_ovf;
`endif

endmodule
